// File: rtl/temp_accumulator.sv
// Read-modify-write accumulator in front of temp_buffer.
// Sums tagged partial sums into temp slots and emits the total on the last beat.
module temp_accumulator #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              ovf,
  output logic [ADDR_W-1:0] temp_address,
  output logic              temp_write,
  output logic [DATA_W-1:0] temp_in,
  input  logic [DATA_W-1:0] temp_out
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    OUT
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] sum_q;
  logic              first_q;
  logic              last_q;
  logic [DATA_W:0]   add_w;
  logic              accept;

  assign add_w = {1'b0, temp_out} + {1'b0, data_q};
  assign accept = in_valid & in_ready;

  assign temp_address = addr_q;
  assign out_addr = addr_q;
  assign out_data = sum_q;

  always_comb begin
    state_d = state_q;
    in_ready = 1'b0;
    out_valid = 1'b0;
    temp_write = 1'b0;
    temp_in = first_q ? data_q : add_w[DATA_W-1:0];
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = in_first ? WR : RD;
      end
      RD: state_d = WR;
      WR: begin
        temp_write = 1'b1;
        state_d = last_q ? OUT : IDLE;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset drops an in-flight beat, so no write may escape this cycle.
    if (rst) begin
      in_ready = 1'b0;
      out_valid = 1'b0;
      temp_write = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      sum_q <= '0;
      first_q <= 1'b0;
      last_q <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= in_addr;
        data_q <= in_data;
        first_q <= in_first;
        last_q <= in_last;
      end
      if (state_q == WR) begin
        sum_q <= temp_in;
        if (!first_q && add_w[DATA_W]) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_temp_accumulator.sv
// Bench for temp_accumulator with a temp_buffer memory model
// and a slot-level reference of the accumulated sums.
module tb_temp_accumulator;

  localparam int DW = 36;
  localparam int AW = 2;

  logic          clk = 0;
  logic          rst = 1;
  logic          in_valid = 0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_first = 0;
  logic          in_last = 0;
  logic          out_valid;
  logic          out_ready = 0;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          ovf;
  logic [AW-1:0] temp_address;
  logic          temp_write;
  logic [DW-1:0] temp_in;
  logic [DW-1:0] temp_out = '0;

  logic [DW-1:0] mem [4];
  logic [DW-1:0] ref_mem [4];
  logic          ref_ovf = 0;
  int            n_pass = 0;
  int            n_total = 0;

  temp_accumulator #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data),
    .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .ovf(ovf),
    .temp_address(temp_address), .temp_write(temp_write),
    .temp_in(temp_in), .temp_out(temp_out)
  );

  always #5 clk = ~clk;

  // temp_buffer: read data one cycle after the address is sampled.
  always @(posedge clk) begin
    if (temp_write) mem[temp_address] <= temp_in;
    temp_out <= mem[temp_address];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic f, input logic l, output bit ok);
    int n = 0;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    ok = in_ready;
    in_valid = 1;
    in_addr = a;
    in_data = d;
    in_first = f;
    in_last = l;
    tick();
    in_valid = 0;
  endtask

  task automatic beat(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic f, input logic l, input int stall);
    bit ok;
    logic [DW:0] full;
    logic [DW-1:0] exp;
    full = f ? {1'b0, d} : {1'b0, ref_mem[a]} + {1'b0, d};
    exp = full[DW-1:0];
    accept(a, d, f, l, ok);
    n_total++;
    if (!ok) $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
    else n_pass++;
    if (!f) begin
      n_total++;
      if (temp_write !== 1'b0 || temp_address !== a)
        $display("FAIL read_cycle we=%0b addr=%0d required we=0 addr=%0d",
                 temp_write, temp_address, a);
      else n_pass++;
      tick();
    end
    n_total++;
    if (temp_write !== 1'b1 || temp_address !== a || temp_in !== exp)
      $display("FAIL write_cycle we=%0b addr=%0d data=%h required 1 %0d %h",
               temp_write, temp_address, temp_in, a, exp);
    else n_pass++;
    ref_mem[a] = exp;
    if (!f && full[DW]) ref_ovf = 1;
    tick();
    n_total++;
    if (ovf !== ref_ovf)
      $display("FAIL ovf got=%0b required %0b", ovf, ref_ovf);
    else n_pass++;
    if (l) begin
      for (int i = 0; i <= stall; i++) begin
        n_total++;
        if (out_valid !== 1'b1 || out_addr !== a || out_data !== exp ||
            in_ready !== 1'b0)
          $display("FAIL out_hold%0d v=%0b a=%0d d=%h rdy=%0b required 1 %0d %h 0",
                   i, out_valid, out_addr, out_data, in_ready, a, exp);
        else n_pass++;
        if (i < stall) tick();
      end
      out_ready = 1;
      tick();
      out_ready = 0;
    end
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL back_idle v=%0b rdy=%0b required 0 1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1;
    in_valid = 0;
    tick();
    tick();
    n_total++;
    if (in_ready !== 0 || out_valid !== 0 || temp_write !== 0 || ovf !== 0)
      $display("FAIL reset rdy=%0b v=%0b we=%0b ovf=%0b required all 0",
               in_ready, out_valid, temp_write, ovf);
    else n_pass++;
    rst = 0;
    ref_ovf = 0;
    #1;
    n_total++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_release in_ready=%0b required 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    beat(1, 5, 1, 0, 0);
    beat(1, 7, 0, 1, 0);
  endtask

  task automatic test_stall();
    beat(1, 5, 1, 0, 0);
    beat(1, 7, 0, 1, 3);
  endtask

  task automatic test_overflow();
    beat(0, 36'hF_FFFF_FFFF, 1, 0, 0);
    beat(0, 2, 0, 1, 0);
    repeat (3) tick();
    n_total++;
    if (ovf !== 1'b1) $display("FAIL ovf_sticky got=%0b required 1", ovf);
    else n_pass++;
    test_reset();
  endtask

  task automatic test_mid_reset();
    bit ok;
    logic [DW-1:0] keep;
    beat(2, 99, 1, 0, 0);
    keep = ref_mem[2];
    accept(2, 50, 0, 1, ok);
    rst = 1;
    #1;
    n_total++;
    if (temp_write !== 1'b0)
      $display("FAIL rst_in_rd we=%0b required 0", temp_write);
    else n_pass++;
    tick();
    rst = 0;
    #1;
    n_total++;
    if (in_ready !== 1'b1 || mem[2] !== keep)
      $display("FAIL rst_rd_after rdy=%0b slot=%h required 1 %h",
               in_ready, mem[2], keep);
    else n_pass++;
    accept(2, 50, 0, 1, ok);
    tick();
    rst = 1;
    #1;
    n_total++;
    if (temp_write !== 1'b0)
      $display("FAIL rst_in_wr we=%0b required 0", temp_write);
    else n_pass++;
    tick();
    rst = 0;
    #1;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem[2] !== keep)
      $display("FAIL rst_wr_after rdy=%0b v=%0b slot=%h required 1 0 %h",
               in_ready, out_valid, mem[2], keep);
    else n_pass++;
    ref_ovf = 0;
    beat(2, 0, 0, 1, 0);
  endtask

  task automatic test_interleave();
    for (int s = 0; s < 4; s++) beat(AW'(s), DW'(10 * (s + 1)), 1, 0, 0);
    for (int s = 0; s < 4; s++) beat(AW'(s), 1, 0, 1, 0);
  endtask

  task automatic test_first_last();
    beat(3, 36'h1234_5678_9, 1, 1, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] d;
      d = {4'($urandom), 32'($urandom)};
      beat(AW'($urandom_range(3, 0)), d, $urandom_range(2, 0) == 0,
           1'($urandom), $urandom_range(2, 0));
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_mid_reset();
    test_interleave();
    test_first_last();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
